// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-stage definitions: next-PC kind encodings, reset PC, NOP word
// and the branch-target helper.
package ifu_fetch_pkg;

  typedef enum logic [2:0] {
    NPC_SEQ  = 3'd0,
    NPC_BEQ  = 3'd1,
    NPC_BNE  = 3'd2,
    NPC_BGEZ = 3'd3,
    NPC_BLTZ = 3'd4,
    NPC_J    = 3'd5,
    NPC_JR   = 3'd6,
    NPC_RSVD = 3'd7
  } npc_op_e;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam int unsigned IM_WORDS_DEF = 4096;

  function automatic logic [31:0] branch_target(input logic [31:0] pc_id,
                                                input logic [15:0] imm16);
    return pc_id + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_npc_calc.sv
// Combinational next-PC resolution: taken decision for the instruction in ID
// plus target selection; falls back to sequential pc+4.
module npc_calc
  import ifu_fetch_pkg::*;
(
  input  logic [2:0]  npc_op,
  input  logic [31:0] pc,
  input  logic [31:0] pc_id,
  input  logic [15:0] imm16,
  input  logic [25:0] idx26,
  input  logic [31:0] rs_val,
  input  logic        eql,
  input  logic        ltz,
  output logic [31:0] npc
);

  npc_op_e     op;
  logic        taken;
  logic [31:0] target;

  always_comb begin
    op     = npc_op_e'(npc_op);
    taken  = 1'b0;
    target = branch_target(pc_id, imm16);
    case (op)
      NPC_BEQ:  taken = eql;
      NPC_BNE:  taken = !eql;
      NPC_BGEZ: taken = !ltz;
      NPC_BLTZ: taken = ltz;
      NPC_J: begin
        taken  = 1'b1;
        target = {pc_id[31:28], idx26, 2'b00};
      end
      NPC_JR: begin
        taken  = 1'b1;
        target = rs_val;
      end
      default:  taken = 1'b0;
    endcase
    npc = taken ? target : pc + 32'd4;
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: PC register, instruction-memory addressing,
// sticky fetch-fault detection and accepted-fetch counter.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int unsigned IM_WORDS = IM_WORDS_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF,
  localparam int unsigned AW      = $clog2(IM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    npc_op,
  input  logic [31:0]   pc_id,
  input  logic [15:0]   imm16,
  input  logic [25:0]   idx26,
  input  logic [31:0]   rs_val,
  input  logic          eql,
  input  logic          ltz,
  output logic [AW-1:0] im_addr,
  input  logic [31:0]   im_rdata,
  output logic [31:0]   instr_if,
  output logic [31:0]   pc_if,
  output logic          fault,
  output logic [31:0]   fetch_cnt
);

  localparam logic [32:0] IM_BYTES = 33'(IM_WORDS) << 2;

  logic [31:0] pc;
  logic [31:0] pc_off;
  logic [31:0] npc;
  logic        in_range;
  logic        fault_det;

  npc_calc u_npc_calc (
    .npc_op (npc_op),
    .pc     (pc),
    .pc_id  (pc_id),
    .imm16  (imm16),
    .idx26  (idx26),
    .rs_val (rs_val),
    .eql    (eql),
    .ltz    (ltz),
    .npc    (npc)
  );

  // Unsigned offset compare also catches PCs below PC_RESET (they wrap high).
  always_comb begin
    pc_off    = pc - PC_RESET;
    in_range  = {1'b0, pc_off} < IM_BYTES;
    fault_det = (pc[1:0] != 2'b00) || !in_range;
    im_addr   = pc_off[AW+1:2];
    pc_if     = pc;
    instr_if  = (fault || fault_det) ? NOP_WORD : im_rdata;
  end

  // On the detect edge the PC is held so the faulting address stays visible;
  // the counter still steps because fault was not yet set on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= PC_RESET;
      fault     <= 1'b0;
      fetch_cnt <= '0;
    end else if (en && !fault) begin
      fetch_cnt <= fetch_cnt + 32'd1;
      if (fault_det) fault <= 1'b1;
      else           pc    <= npc;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus randomized
// redirect/stall traffic against a behavioural model of the fetch rules.
module tb_ifu_fetch;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    npc_op = '0;
  logic [31:0]   pc_id = '0;
  logic [15:0]   imm16 = '0;
  logic [25:0]   idx26 = '0;
  logic [31:0]   rs_val = '0;
  logic          eql = 1'b0;
  logic          ltz = 1'b0;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_rdata;
  logic [31:0]   instr_if;
  logic [31:0]   pc_if;
  logic          fault;
  logic [31:0]   fetch_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] pc_m;
  logic        f_m;
  logic [31:0] cnt_m;

  ifu_fetch #(.PC_RESET(32'h0000_3000), .IM_WORDS(4096), .NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .en(en), .npc_op(npc_op), .pc_id(pc_id), .imm16(imm16),
    .idx26(idx26), .rs_val(rs_val), .eql(eql), .ltz(ltz), .im_addr(im_addr),
    .im_rdata(im_rdata), .instr_if(instr_if), .pc_if(pc_if), .fault(fault),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a recognisable pattern per word index.
  assign im_rdata = 32'hA5A5_0000 ^ 32'(im_addr);

  function automatic logic bad_pc(input logic [31:0] p);
    return (p % 4 != 0) || (p < 32'h3000) || (p >= 32'h3000 + 32'd16384);
  endfunction

  function automatic logic [31:0] exp_instr();
    if (f_m || bad_pc(pc_m)) return 32'h0;
    return 32'hA5A5_0000 ^ ((pc_m - 32'h3000) / 4);
  endfunction

  function automatic logic [31:0] model_next();
    int d;
    logic tk;
    logic [31:0] tg;
    d  = $signed(imm16);
    tg = pc_id + 32'd4 + 32'(d * 4);
    case (npc_op)
      3'd1: tk = eql;
      3'd2: tk = !eql;
      3'd3: tk = !ltz;
      3'd4: tk = ltz;
      3'd5: begin tk = 1'b1; tg = (pc_id & 32'hF000_0000) + 32'(idx26) * 4; end
      3'd6: begin tk = 1'b1; tg = rs_val; end
      default: tk = 1'b0;
    endcase
    return tk ? tg : pc_m + 32'd4;
  endfunction

  // One clock edge; the model consumes the same inputs the DUT sees.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      pc_m = 32'h3000; f_m = 1'b0; cnt_m = '0;
    end else if (en && !f_m) begin
      cnt_m = cnt_m + 1;
      if (bad_pc(pc_m)) f_m = 1'b1;
      else pc_m = model_next();
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; npc_op = 3'd0;
    tick();
    rst = 1'b0;
    checks++;
    if (pc_if !== 32'h3000 || fetch_cnt !== 32'd0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc_if=%h cnt=%0d fault=%b, want 3000 0 0", pc_if, fetch_cnt, fault);
    end
    checks++;
    if (instr_if !== exp_instr()) begin
      errors++;
      $display("FAIL reset_instr: got %h want %h", instr_if, exp_instr());
    end
  endtask

  task automatic test_seq();
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (pc_if !== 32'h3000 + 32'(4 * i) || fetch_cnt !== 32'(i) || fault !== 1'b0) begin
        errors++;
        $display("FAIL seq%0d: pc_if=%h cnt=%0d fault=%b", i, pc_if, fetch_cnt, fault);
      end
    end
  endtask

  task automatic test_branches();
    pc_id = 32'h3004; imm16 = 16'h0003; eql = 1'b1; npc_op = 3'd1;
    tick();
    checks++;
    if (pc_if !== 32'h3014) begin
      errors++; $display("FAIL beq_taken: pc_if=%h want 00003014", pc_if);
    end
    npc_op = 3'd0; rst = 1'b1; tick(); rst = 1'b0; tick(); tick();
    pc_id = 32'h3004; eql = 1'b0; npc_op = 3'd1;
    tick();
    checks++;
    if (pc_if !== 32'h300C) begin
      errors++; $display("FAIL beq_not_taken: pc_if=%h want 0000300c", pc_if);
    end
    pc_id = 32'h3010; imm16 = 16'hFFFE; ltz = 1'b1; npc_op = 3'd4;
    tick();
    checks++;
    if (pc_if !== 32'h300C) begin
      errors++; $display("FAIL bltz_neg: pc_if=%h want 0000300c", pc_if);
    end
    pc_id = 32'h3020; idx26 = 26'h0000C10; npc_op = 3'd5;
    tick();
    checks++;
    if (pc_if !== 32'h3040) begin
      errors++; $display("FAIL j: pc_if=%h want 00003040", pc_if);
    end
    rs_val = 32'h0000_3100; npc_op = 3'd6;
    tick();
    checks++;
    if (pc_if !== 32'h3100 || instr_if !== exp_instr()) begin
      errors++; $display("FAIL jr: pc_if=%h instr=%h want 00003100 %h", pc_if, instr_if, exp_instr());
    end
    npc_op = 3'd0;
  endtask

  task automatic test_stall();
    logic [31:0] pc0, ins0, cnt0;
    pc0 = pc_if; ins0 = instr_if; cnt0 = fetch_cnt;
    en = 1'b0; npc_op = 3'd1; eql = 1'b1; pc_id = pc0 - 4; imm16 = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc_if !== pc0 || instr_if !== ins0 || fetch_cnt !== cnt0) begin
        errors++;
        $display("FAIL stall%0d: pc_if=%h instr=%h cnt=%0d want %h %h %0d",
                 i, pc_if, instr_if, fetch_cnt, pc0, ins0, cnt0);
      end
    end
    en = 1'b1;
    tick();
    npc_op = 3'd0;
    checks++;
    if (pc_if !== pc0 + 32'h40 || fetch_cnt !== cnt0 + 1) begin
      errors++; $display("FAIL stall_release: pc_if=%h cnt=%0d want %h %0d", pc_if, fetch_cnt, pc0 + 32'h40, cnt0 + 1);
    end
    tick();
    checks++;
    if (pc_if !== pc0 + 32'h44) begin
      errors++; $display("FAIL stall_once: pc_if=%h want %h", pc_if, pc0 + 32'h44);
    end
  endtask

  task automatic test_fault();
    rs_val = 32'h0000_3002; npc_op = 3'd6;
    tick();
    npc_op = 3'd0;
    checks++;
    if (pc_if !== 32'h3002 || instr_if !== 32'h0 || fault !== 1'b0) begin
      errors++; $display("FAIL fault_same_cycle: pc_if=%h instr=%h fault=%b want 00003002 0 0", pc_if, instr_if, fault);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (pc_if !== 32'h3002 || instr_if !== 32'h0 || fault !== 1'b1 || fetch_cnt !== cnt_m) begin
        errors++;
        $display("FAIL fault_hold%0d: pc_if=%h instr=%h fault=%b cnt=%0d want 00003002 0 1 %0d",
                 i, pc_if, instr_if, fault, fetch_cnt, cnt_m);
      end
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (pc_if !== 32'h3000 || fault !== 1'b0 || fetch_cnt !== 32'd0) begin
      errors++; $display("FAIL fault_clear: pc_if=%h fault=%b cnt=%0d want 3000 0 0", pc_if, fault, fetch_cnt);
    end
  endtask

  task automatic test_range();
    rs_val = 32'h0000_6FFC; npc_op = 3'd6;
    tick();
    rs_val = 32'h0000_7000;
    tick();
    checks++;
    if (pc_if !== 32'h7000 || fault !== 1'b0 || instr_if !== 32'h0) begin
      errors++; $display("FAIL range_edge: pc_if=%h fault=%b instr=%h want 00007000 0 0", pc_if, fault, instr_if);
    end
    npc_op = 3'd0;
    tick();
    checks++;
    if (fault !== 1'b1 || pc_if !== 32'h7000) begin
      errors++; $display("FAIL range_fault: fault=%b pc_if=%h want 1 00007000", fault, pc_if);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    rs_val = 32'h0000_6FFC; npc_op = 3'd6;
    tick();
    npc_op = 3'd0;
    checks++;
    if (im_addr !== 12'hFFF || instr_if !== 32'hA5A5_0FFF || fault !== 1'b0) begin
      errors++; $display("FAIL last_word: im_addr=%h instr=%h fault=%b want fff a5a50fff 0", im_addr, instr_if, fault);
    end
    tick();
    tick();
    checks++;
    if (fault !== 1'b1) begin
      errors++; $display("FAIL past_end: fault=%b want 1", fault);
    end
  endtask

  task automatic test_reset_mid_redirect();
    pc_id = pc_if - 4; imm16 = 16'h0020; eql = 1'b1; npc_op = 3'd1; rst = 1'b1;
    tick();
    rst = 1'b0; npc_op = 3'd0;
    checks++;
    if (pc_if !== 32'h3000 || fault !== 1'b0 || fetch_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_mid_branch: pc_if=%h fault=%b cnt=%0d want 3000 0 0", pc_if, fault, fetch_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en     = ($urandom_range(0, 4) != 0);
      rst    = ($urandom_range(0, 60) == 0) || (f_m && $urandom_range(0, 3) == 0);
      npc_op = 3'($urandom_range(0, 7));
      pc_id  = pc_m - 4;
      imm16  = 16'($signed($urandom_range(0, 40)) - 20);
      idx26  = 26'(32'h0C00 + $urandom_range(0, 4095));
      rs_val = 32'h3000 + 32'($urandom_range(0, 4100)) * 4 + (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd0);
      eql    = 1'($urandom);
      ltz    = 1'($urandom);
      tick();
      checks++;
      if (pc_if !== pc_m || fault !== f_m || fetch_cnt !== cnt_m || instr_if !== exp_instr()) begin
        errors++;
        $display("FAIL random%0d: pc=%h f=%b cnt=%0d ins=%h want %h %b %0d %h",
                 i, pc_if, fault, fetch_cnt, instr_if, pc_m, f_m, cnt_m, exp_instr());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    pc_m = 32'h3000; f_m = 1'b0; cnt_m = '0;
    @(negedge clk);
    test_reset();
    test_seq();
    test_branches();
    test_stall();
    test_fault();
    test_range();
    test_reset_mid_redirect();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
